// File: rtl/frame_tx_stats.sv
// frame_tx_stats: registered AXIS skid buffer with per-id frame/byte counters.
// Define FRAME_TX_STATS_RUNT_EN to also build the per-id runt (<60 byte) counters.
module frame_tx_stats #(
  parameter int DATA_WIDTH = 512,
  parameter int ID_WIDTH   = 3,
  parameter int CNT_WIDTH  = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   axis_s_data,
  input  logic [DATA_WIDTH/8-1:0] axis_s_keep,
  input  logic                    axis_s_last,
  input  logic [DATA_WIDTH/8-1:0] axis_s_user,
  input  logic [ID_WIDTH-1:0]     axis_s_id,
  input  logic                    axis_s_valid,
  output logic                    axis_s_ready,
  output logic [DATA_WIDTH-1:0]   axis_m_data,
  output logic [DATA_WIDTH/8-1:0] axis_m_keep,
  output logic                    axis_m_last,
  output logic [DATA_WIDTH/8-1:0] axis_m_user,
  output logic [ID_WIDTH-1:0]     axis_m_id,
  output logic                    axis_m_valid,
  input  logic                    axis_m_ready,
  input  logic                    clear,
  input  logic [ID_WIDTH-1:0]     stat_sel,
  output logic [CNT_WIDTH-1:0]    stat_frames,
  output logic [CNT_WIDTH-1:0]    stat_bytes,
  output logic [CNT_WIDTH-1:0]    stat_runts
);

  localparam int KW  = DATA_WIDTH / 8;
  localparam int PW  = $clog2(KW) + 1;
  localparam int NID = 2 ** ID_WIDTH;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [KW-1:0]         keep;
    logic                  last;
    logic [KW-1:0]         user;
    logic [ID_WIDTH-1:0]   id;
  } beat_t;

  function automatic logic [PW-1:0] popcount(input logic [KW-1:0] k);
    logic [PW-1:0] n;
    n = {PW{1'b0}};
    for (int i = 0; i < KW; i++) begin
      n = n + {{(PW-1){1'b0}}, k[i]};
    end
    return n;
  endfunction

  beat_t in_beat_s;
  beat_t main_q, main_d, skid_q, skid_d;
  logic  main_vld_q, main_vld_d, skid_vld_q, skid_vld_d, rdy_q, rdy_d;
  logic  in_fire_s, out_fire_s;

  assign in_beat_s = {axis_s_data, axis_s_keep, axis_s_last, axis_s_user, axis_s_id};

  // Skid buffer next state: main refills from skid first so beat order holds.
  always_comb begin
    in_fire_s  = axis_s_valid && rdy_q;
    out_fire_s = main_vld_q && axis_m_ready;
    main_d     = main_q;
    main_vld_d = main_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    if (!main_vld_q || out_fire_s) begin
      if (skid_vld_q) begin
        main_d     = skid_q;
        main_vld_d = 1'b1;
        skid_vld_d = 1'b0;
      end else if (in_fire_s) begin
        main_d     = in_beat_s;
        main_vld_d = 1'b1;
      end else begin
        main_vld_d = 1'b0;
      end
    end else if (in_fire_s) begin
      skid_d     = in_beat_s;
      skid_vld_d = 1'b1;
    end else begin
      skid_vld_d = skid_vld_q;
    end
    rdy_d = !skid_vld_d;
  end

  // Skid buffer registers; ready stays low during reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      rdy_q      <= 1'b0;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
      rdy_q      <= rdy_d;
    end
  end

  assign axis_s_ready = rdy_q;
  assign axis_m_valid = main_vld_q;
  assign axis_m_data  = main_q.data;
  assign axis_m_keep  = main_q.keep;
  assign axis_m_last  = main_q.last;
  assign axis_m_user  = main_q.user;
  assign axis_m_id    = main_q.id;

  logic                s1_vld_q, s1_vld_d, s1_last_q, s1_last_d;
  logic [ID_WIDTH-1:0] s1_id_q, s1_id_d;
  logic [PW-1:0]       s1_pop_q, s1_pop_d;

  // Stage 1 capture of the accepted beat's counting fields.
  always_comb begin
    s1_vld_d = in_fire_s;
    if (in_fire_s) begin
      s1_id_d   = axis_s_id;
      s1_last_d = axis_s_last;
      s1_pop_d  = popcount(axis_s_keep);
    end else begin
      s1_id_d   = s1_id_q;
      s1_last_d = s1_last_q;
      s1_pop_d  = s1_pop_q;
    end
  end

  // Stage 1 registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld_q  <= 1'b0;
      s1_last_q <= 1'b0;
      s1_id_q   <= {ID_WIDTH{1'b0}};
      s1_pop_q  <= {PW{1'b0}};
    end else begin
      s1_vld_q  <= s1_vld_d;
      s1_last_q <= s1_last_d;
      s1_id_q   <= s1_id_d;
      s1_pop_q  <= s1_pop_d;
    end
  end

  logic [CNT_WIDTH-1:0] frames_q [NID];
  logic [CNT_WIDTH-1:0] frames_d [NID];
  logic [CNT_WIDTH-1:0] bytes_q  [NID];
  logic [CNT_WIDTH-1:0] bytes_d  [NID];
  logic [CNT_WIDTH-1:0] stat_frames_q, stat_frames_d, stat_bytes_q, stat_bytes_d;
  logic [CNT_WIDTH-1:0] stat_runts_q, stat_runts_d;

  // Stage 2: clear first, then add; the RMW completes in one cycle so back-to-back beats chain.
  always_comb begin
    for (int i = 0; i < NID; i++) begin
      if (clear) begin
        frames_d[i] = {CNT_WIDTH{1'b0}};
        bytes_d[i]  = {CNT_WIDTH{1'b0}};
      end else begin
        frames_d[i] = frames_q[i];
        bytes_d[i]  = bytes_q[i];
      end
    end
    if (s1_vld_q) begin
      bytes_d[s1_id_q]  = bytes_d[s1_id_q] + CNT_WIDTH'(s1_pop_q);
      frames_d[s1_id_q] = frames_d[s1_id_q] + {{(CNT_WIDTH-1){1'b0}}, s1_last_q};
    end else begin
      bytes_d[s1_id_q]  = bytes_d[s1_id_q];
    end
    stat_frames_d = frames_q[stat_sel];
    stat_bytes_d  = bytes_q[stat_sel];
  end

  // Counter arrays and readout registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NID; i++) begin
        frames_q[i] <= {CNT_WIDTH{1'b0}};
        bytes_q[i]  <= {CNT_WIDTH{1'b0}};
      end
      stat_frames_q <= {CNT_WIDTH{1'b0}};
      stat_bytes_q  <= {CNT_WIDTH{1'b0}};
      stat_runts_q  <= {CNT_WIDTH{1'b0}};
    end else begin
      for (int i = 0; i < NID; i++) begin
        frames_q[i] <= frames_d[i];
        bytes_q[i]  <= bytes_d[i];
      end
      stat_frames_q <= stat_frames_d;
      stat_bytes_q  <= stat_bytes_d;
      stat_runts_q  <= stat_runts_d;
    end
  end

`ifdef FRAME_TX_STATS_RUNT_EN
  localparam logic [CNT_WIDTH-1:0] RUNT_MIN = CNT_WIDTH'(7'd60);

  logic [CNT_WIDTH-1:0] len_q, len_d, len_sum_s;
  logic [CNT_WIDTH-1:0] runts_q [NID];
  logic [CNT_WIDTH-1:0] runts_d [NID];

  // Frame length accumulator shared by all ids, since frames never interleave.
  always_comb begin
    len_sum_s = len_q + CNT_WIDTH'(s1_pop_q);
    len_d     = len_q;
    for (int i = 0; i < NID; i++) begin
      if (clear) begin
        runts_d[i] = {CNT_WIDTH{1'b0}};
      end else begin
        runts_d[i] = runts_q[i];
      end
    end
    if (s1_vld_q) begin
      if (s1_last_q) begin
        len_d = {CNT_WIDTH{1'b0}};
        if (len_sum_s < RUNT_MIN) begin
          runts_d[s1_id_q] = runts_d[s1_id_q] + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
          runts_d[s1_id_q] = runts_d[s1_id_q];
        end
      end else begin
        len_d = len_sum_s;
      end
    end else begin
      len_d = len_q;
    end
    stat_runts_d = runts_q[stat_sel];
  end

  // Runt accumulator and counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q <= {CNT_WIDTH{1'b0}};
      for (int i = 0; i < NID; i++) begin
        runts_q[i] <= {CNT_WIDTH{1'b0}};
      end
    end else begin
      len_q <= len_d;
      for (int i = 0; i < NID; i++) begin
        runts_q[i] <= runts_d[i];
      end
    end
  end
`else
  assign stat_runts_d = {CNT_WIDTH{1'b0}};
`endif

  assign stat_frames = stat_frames_q;
  assign stat_bytes  = stat_bytes_q;
  assign stat_runts  = stat_runts_q;

endmodule

// File: tb/tb_frame_tx_stats.sv
// Self-checking bench for frame_tx_stats: directed and random traffic against a
// beat-queue scoreboard and per-id counter model; a CNT_WIDTH=8 instance covers wrap.
`timescale 1ns/1ps
module tb_frame_tx_stats;
  localparam int DW  = 512;
  localparam int KW  = 64;
  localparam int IW  = 3;
  localparam int CW  = 64;
  localparam int NID = 8;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    logic [KW-1:0] user;
    logic [IW-1:0] id;
  } beat_t;

  logic clk, rst;
  logic [DW-1:0] s_data;
  logic [KW-1:0] s_keep, s_user;
  logic s_last, s_valid, s_ready;
  logic [IW-1:0] s_id;
  logic [DW-1:0] m_data;
  logic [KW-1:0] m_keep, m_user;
  logic m_last, m_valid, m_ready;
  logic [IW-1:0] m_id;
  logic clear;
  logic [IW-1:0] stat_sel;
  logic [CW-1:0] st_frames, st_bytes, st_runts;

  logic w_valid, w_ready, w_m_ready, w_clear;
  logic [DW-1:0] w_m_data;
  logic [KW-1:0] w_m_keep, w_m_user;
  logic w_m_last, w_m_valid;
  logic [IW-1:0] w_m_id, w_sel;
  logic [7:0] w_frames, w_bytes, w_runts;

  frame_tx_stats dut (
    .clk(clk), .rst(rst),
    .axis_s_data(s_data), .axis_s_keep(s_keep), .axis_s_last(s_last),
    .axis_s_user(s_user), .axis_s_id(s_id), .axis_s_valid(s_valid), .axis_s_ready(s_ready),
    .axis_m_data(m_data), .axis_m_keep(m_keep), .axis_m_last(m_last),
    .axis_m_user(m_user), .axis_m_id(m_id), .axis_m_valid(m_valid), .axis_m_ready(m_ready),
    .clear(clear), .stat_sel(stat_sel),
    .stat_frames(st_frames), .stat_bytes(st_bytes), .stat_runts(st_runts)
  );

  frame_tx_stats #(.CNT_WIDTH(8)) dut_w (
    .clk(clk), .rst(rst),
    .axis_s_data(s_data), .axis_s_keep(s_keep), .axis_s_last(s_last),
    .axis_s_user(s_user), .axis_s_id(s_id), .axis_s_valid(w_valid), .axis_s_ready(w_ready),
    .axis_m_data(w_m_data), .axis_m_keep(w_m_keep), .axis_m_last(w_m_last),
    .axis_m_user(w_m_user), .axis_m_id(w_m_id), .axis_m_valid(w_m_valid), .axis_m_ready(w_m_ready),
    .clear(w_clear), .stat_sel(w_sel),
    .stat_frames(w_frames), .stat_bytes(w_bytes), .stat_runts(w_runts)
  );

  int checks = 0;
  int errors = 0;
  bit rnd_rdy = 1'b0;

  beat_t exp_q[$];
  logic [CW-1:0] mf[NID];
  logic [CW-1:0] mb[NID];
  logic [CW-1:0] mr[NID];
  logic [CW-1:0] mlen;
  longint acc_cnt = 0;
  longint out_cnt = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: observed no finish, required finish before 500us");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Commit an accepted beat to the counter model using the plain counting rules.
  task automatic model_commit(input beat_t b);
    int pop;
    pop = $countones(b.keep);
    mb[b.id] = mb[b.id] + CW'(pop);
    if (b.last) mf[b.id] = mf[b.id] + 64'd1;
`ifdef FRAME_TX_STATS_RUNT_EN
    mlen = mlen + CW'(pop);
    if (b.last) begin
      if (mlen < 64'd60) mr[b.id] = mr[b.id] + 64'd1;
      mlen = 64'd0;
    end
`endif
  endtask

  // Monitor: scoreboard, stall stability, ready-vs-occupancy and counter model.
  initial begin
    beat_t pend, prev_out, cur_out, inb, e;
    bit pend_v, stall_prev;
    pend_v = 1'b0;
    stall_prev = 1'b0;
    mlen = '0;
    for (int i = 0; i < NID; i++) begin mf[i] = '0; mb[i] = '0; mr[i] = '0; end
    forever begin
      @(negedge clk);
      if (!rst) begin
        cur_out = {m_data, m_keep, m_last, m_user, m_id};
        inb     = {s_data, s_keep, s_last, s_user, s_id};
        if (stall_prev) begin
          chk("stall_valid", m_valid, 1'b1);
          chk("stall_hold", cur_out[DW+2*KW+IW:DW], prev_out[DW+2*KW+IW:DW]);
          chk("stall_data", cur_out.data, prev_out.data);
        end
        if (s_ready) chk("ready_occ", ((acc_cnt - out_cnt) <= 1), 1'b1);
        if (clear) begin
          for (int i = 0; i < NID; i++) begin mf[i] = '0; mb[i] = '0; mr[i] = '0; end
        end
        if (pend_v) model_commit(pend);
        pend_v = s_valid && s_ready;
        pend   = inb;
        if (s_valid && s_ready) begin
          exp_q.push_back(inb);
          acc_cnt++;
        end
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            chk("out_spurious", 1'b1, 1'b0);
          end else begin
            e = exp_q.pop_front();
            chk("out_data", m_data, e.data);
            chk("out_side", {m_keep, m_last, m_user, m_id}, {e.keep, e.last, e.user, e.id});
          end
          out_cnt++;
        end
        stall_prev = m_valid && !m_ready;
        prev_out   = cur_out;
      end
    end
  end

  // Random output backpressure while enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_rdy) m_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic send(input beat_t b);
    int guard;
    s_data = b.data; s_keep = b.keep; s_last = b.last; s_user = b.user; s_id = b.id;
    s_valid = 1'b1;
    guard = 0;
    @(negedge clk);
    while (!s_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk("send_ready_wait", s_ready, 1'b1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  function automatic beat_t mk(input logic [IW-1:0] id, input logic [KW-1:0] keep, input logic last);
    beat_t b;
    for (int k = 0; k < DW / 32; k++) b.data[k*32 +: 32] = $urandom;
    b.user = {$urandom, $urandom};
    b.keep = keep;
    b.last = last;
    b.id   = id;
    return b;
  endfunction

  task automatic read_stat(input logic [IW-1:0] id);
    repeat (3) @(posedge clk);
    #1;
    stat_sel = id;
    @(posedge clk);
    #1;
  endtask

  task automatic check_stats();
    repeat (3) @(posedge clk);
    for (int i = 0; i < NID; i++) begin
      #1;
      stat_sel = IW'(i);
      @(posedge clk);
      #1;
      chk($sformatf("frames[%0d]", i), st_frames, mf[i]);
      chk($sformatf("bytes[%0d]", i), st_bytes, mb[i]);
`ifdef FRAME_TX_STATS_RUNT_EN
      chk($sformatf("runts[%0d]", i), st_runts, mr[i]);
`else
      chk($sformatf("runts[%0d]", i), st_runts, 64'd0);
`endif
    end
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
  endtask

  task automatic w_beats(input int n);
    int cnt;
    int guard;
    cnt = 0;
    guard = 0;
    w_valid = 1'b1;
    while (cnt < n && guard < 1000) begin
      @(negedge clk);
      if (w_ready) cnt++;
      @(posedge clk);
      #1;
      guard++;
    end
    w_valid = 1'b0;
    chk("w_beats_done", cnt, n);
  endtask

  initial begin
    beat_t b;
    int guard;
    logic [KW-1:0] kk;
    rst = 1'b1;
    s_valid = 1'b0; s_data = '0; s_keep = '0; s_last = 1'b0; s_user = '0; s_id = '0;
    m_ready = 1'b1; clear = 1'b0; stat_sel = '0;
    w_valid = 1'b0; w_m_ready = 1'b1; w_clear = 1'b0; w_sel = 3'd3;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_s_ready", s_ready, 1'b0);
    chk("rst_frames", st_frames, 64'd0);
    chk("rst_bytes", st_bytes, 64'd0);
    chk("rst_runts", st_runts, 64'd0);
    rst = 1'b0;
    chk("ready_before_edge", s_ready, 1'b0);
    @(posedge clk);
    #1;
    chk("ready_after_edge", s_ready, 1'b1);

    // Three 2-beat frames on id 2, checking 1-cycle latency on the first beat.
    for (int f = 0; f < 3; f++) begin
      b = mk(3'd2, {KW{1'b1}}, 1'b0);
      send(b);
      if (f == 0) begin
        chk("latency_valid", m_valid, 1'b1);
        chk("latency_data", m_data, b.data);
      end
      send(mk(3'd2, 64'h0F, 1'b1));
    end
    read_stat(3'd2);
    chk("t1_frames2", st_frames, 64'd3);
    chk("t1_bytes2", st_bytes, 64'd204);

    // 100 back-to-back single-beat frames alternating id 0/1.
    for (int i = 0; i < 100; i++) send(mk(IW'(i % 2), {KW{1'b1}}, 1'b1));
    read_stat(3'd0);
    chk("t2_frames0", st_frames, 64'd50);
    chk("t2_bytes0", st_bytes, 64'd3200);
    read_stat(3'd1);
    chk("t2_frames1", st_frames, 64'd50);
    chk("t2_bytes1", st_bytes, 64'd3200);
    check_stats();

    // 1000 random beats under random backpressure.
    rnd_rdy = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      case ($urandom_range(0, 2))
        0: kk = {KW{1'b1}};
        1: kk = '0;
        default: kk = {$urandom, $urandom};
      endcase
      send(mk(IW'($urandom_range(0, NID - 1)), kk, (i == 999) || ($urandom_range(0, 3) == 0)));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    rnd_rdy = 1'b0;
    @(posedge clk);
    #2;
    m_ready = 1'b1;
    guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      @(posedge clk);
      guard++;
    end
    chk("drain_empty", exp_q.size(), 0);
    chk("beat_count", out_cnt, acc_cnt);
    check_stats();

    // Build bytes[5]=1000, then clear coincident with a 64-byte last beat's update.
    pulse_clear();
    for (int i = 0; i < 15; i++) send(mk(3'd5, {KW{1'b1}}, 1'b0));
    send(mk(3'd5, 64'hFF_FFFF_FFFF, 1'b1));
    read_stat(3'd5);
    chk("t4_pre_bytes5", st_bytes, 64'd1000);
    send(mk(3'd5, {KW{1'b1}}, 1'b1));
    pulse_clear();
    read_stat(3'd5);
    chk("t4_bytes5", st_bytes, 64'd64);
    chk("t4_frames5", st_frames, 64'd1);
    read_stat(3'd2);
    chk("t4_frames2", st_frames, 64'd0);
    check_stats();

    // Runt boundary: 60 bytes is not a runt, 59 bytes is.
    pulse_clear();
    send(mk(3'd4, 64'h0FFF_FFFF_FFFF_FFFF, 1'b1));
    send(mk(3'd4, 64'h07FF_FFFF_FFFF_FFFF, 1'b1));
    read_stat(3'd4);
`ifdef FRAME_TX_STATS_RUNT_EN
    chk("t6_runts4", st_runts, 64'd1);
`else
    chk("t6_runts4", st_runts, 64'd0);
`endif
    chk("t6_bytes4", st_bytes, 64'd119);
    check_stats();

    // Wrap on the 8-bit counter instance.
    s_id = 3'd3; s_keep = 64'h1; s_last = 1'b1;
    w_beats(255);
    repeat (4) @(posedge clk);
    #1;
    chk("w_frames_255", w_frames, 8'd255);
    chk("w_bytes_255", w_bytes, 8'd255);
    w_beats(1);
    repeat (4) @(posedge clk);
    #1;
    chk("w_frames_wrap", w_frames, 8'd0);
    chk("w_bytes_wrap", w_bytes, 8'd0);
    chk("w_runts_wrap", w_runts, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_tx_stats.md
Name: frame_tx_stats

Overview:
- Transmit-side statistics stage. Sits directly downstream of frame_generator and upstream of the MAC TX FIFOs.
- Passes the generator's AXIS stream through a registered skid buffer at full throughput.
- Accumulates per-port frame and byte counters, indexed by axis_s_id, that the control logic reads back to compute TX rates.
- Counters are cleared together with the generator start pulse.

Parameters:
DATA_WIDTH, 512, AXIS data width in bits (multiple of 8)
ID_WIDTH, 3, port id width; 2**ID_WIDTH counter sets
CNT_WIDTH, 64, width of each frame/byte counter

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
axis_s_data  in  DATA_WIDTH  input data
axis_s_keep  in  DATA_WIDTH/8  byte enables
axis_s_last  in  1  end of frame
axis_s_user  in  DATA_WIDTH/8  sideband, passed through untouched
axis_s_id  in  ID_WIDTH  destination port
axis_s_valid  in  1  input valid
axis_s_ready  out  1  input ready
axis_m_data  out  DATA_WIDTH  output data
axis_m_keep  out  DATA_WIDTH/8  output keep
axis_m_last  out  1  output last
axis_m_user  out  DATA_WIDTH/8  output user
axis_m_id  out  ID_WIDTH  output id
axis_m_valid  out  1  output valid
axis_m_ready  in  1  output ready
clear  in  1  one-cycle pulse, zero all counters
stat_sel  in  ID_WIDTH  counter set to read
stat_frames  out  CNT_WIDTH  frames counted for stat_sel
stat_bytes  out  CNT_WIDTH  bytes counted for stat_sel
stat_runts  out  CNT_WIDTH  runt frames for stat_sel (see Optional Feature)

Behaviour:
- Reset: asynchronous and active-high, per the already-decided interface. On assertion:
  - axis_m_valid=0, axis_s_ready=0, all counters 0, stat_* = 0.
  - axis_s_ready rises in the first clk edge after rst deasserts.
  - Reset mid-frame drops any buffered beats; no partial frame is replayed.
- Datapath: 2-entry skid buffer (main and skid registers).
  - Latency is 1 cycle from input handshake to axis_m_valid.
  - With axis_m_ready held high, throughput is 1 beat/cycle.
  - axis_s_ready is registered and equals "skid entry empty".
  - When axis_m_ready=0 and main is full, the next accepted beat goes to skid and axis_s_ready drops the following cycle.
  - Beat order is preserved. All sideband fields (data, keep, last, user, id) travel together.
  - axis_m_* stay stable while axis_m_valid=1 and axis_m_ready=0.
- Counting happens on the input handshake (axis_s_valid && axis_s_ready), stage 1:
  - Register id, last, and popcount(axis_s_keep).
  - Popcount is an unsigned $clog2(DATA_WIDTH/8)+1 bit value: 0..64 at default.
- Counting, stage 2:
  - bytes[id] += popcount (zero-extended to CNT_WIDTH).
  - If last, frames[id] += 1.
  - Counters wrap modulo 2**CNT_WIDTH; no saturation.
- Ordering assumption: frames are not interleaved between ids. Every beat's id is taken from that beat itself.
- keep=0 beat: adds 0 bytes. It still counts a frame if last=1.
- clear:
  - All counters of all ids take 0 at the next edge.
  - If a stage-2 update is pending in that same cycle, the counter takes only that update's contribution (clear first, then add).
  - Beats in stage 1 during clear are counted after it.
- Readout:
  - stat_sel is registered. stat_* reflect the counters as of the edge after stat_sel is sampled (1-cycle read latency).
  - Counter updates become visible in stat_* at most 3 cycles after the input handshake.
- Counters are implemented as a register array indexed by id. Adjacent beats to the same id must accumulate correctly, with no lost update (read-modify-write forwarding).

Optional Feature:
- Macro: FRAME_TX_STATS_RUNT_EN.
- When defined:
  - A single frame-length accumulator (CNT_WIDTH bits) sums popcount per beat and resets after last.
  - On last, if total frame length < 60 bytes, runts[id] += 1.
  - runts follow the same clear, wrap, and reset rules as the other counters.
  - stat_runts reads runts[stat_sel].
- When undefined: no accumulator or runt array is built, and stat_runts is tied to 0.

Test Plan:
- Reset, then 3 frames of 2 beats each on id=2: first beat keep=all-ones (64 B), last beat keep=0x0F (4 B), axis_m_ready=1 -> stat_sel=2 gives stat_frames=3 and stat_bytes=204. Output matches input beat-for-beat with latency 1.
- Back-to-back single-beat frames alternating id 0/1, 100 beats, keep=all-ones -> frames[0]=frames[1]=50, bytes[0]=bytes[1]=3200. No lost updates.
- Random axis_m_ready (50%) over 1000 beats -> output sequence identical to input, no drop or duplicate, axis_m_* stable while stalled, axis_s_ready never high when skid is full.
- Pulse clear coincident with the stage-2 update of a 64-byte last beat on id=5 (prior bytes[5]=1000) -> bytes[5]=64, frames[5]=1, all other ids 0.
- Preload frames[3]=2**CNT_WIDTH-1 via CNT_WIDTH=8 build, send 1 frame on id=3 -> frames[3]=0.
- FRAME_TX_STATS_RUNT_EN defined: on id=4, send a 1-beat frame with keep=0x0FFFFFFFFFFFFFFF (60 B) and a 1-beat frame with keep=(1<<59)-1 (59 B) -> runts[4]=1. Undefined: stat_runts=0.
